dataflow_deadlock_monitor: RTL
==============================

DATAFLOW_DEADLOCK_MONITOR -- requirements
Module: dataflow_deadlock_monitor

Parameters
REQ-001 SHALL have parameter N_PROC, default 3: number of monitored dataflow processes (2..32).
REQ-002 SHALL have parameter STALL_LIMIT, default 4: consecutive blocked cycles before a process is armed (1..2^CNT_W-1).
REQ-003 SHALL have parameter CNT_W, default 8: width of each per-process stall counter.
REQ-004 SHALL have parameter IDX_W, default $clog2(N_PROC): width of process index outputs.

Interface
REQ-005 SHALL have port dl_clock, input, 1: the single clock; all state updates on the rising edge.
REQ-006 SHALL have port dl_reset, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port proc_blk, input, N_PROC: bit i high means process i is blocked this cycle.
REQ-008 SHALL have port wait_for, input, N_PROC*N_PROC: bit [i*N_PROC+j] high means process i waits on process j.
REQ-009 SHALL have port all_finish, input, 1: design finished; suppresses detection.
REQ-010 SHALL have port dl_clear, input, 1: one-cycle pulse that releases a latched detection.
REQ-011 SHALL have port dl_detect, output, 1: deadlock latched.
REQ-012 SHALL have port dl_origin, output, IDX_W: index of the process that closed the cycle.
REQ-013 SHALL have port dl_members, output, N_PROC: processes visited by the successful probe.
REQ-014 SHALL have port probe_busy, output, 1: FSM is in PROBE.

Function
REQ-015 SHALL keep stall_cnt[i] per process: incremented while proc_blk[i]=1 and row i of wait_for is non-zero; saturating at STALL_LIMIT; cleared to 0 in any cycle the condition is false.
REQ-016 SHALL define armed[i] = (stall_cnt[i]==STALL_LIMIT), as a registered value.
REQ-017 SHALL implement a three-state FSM with states IDLE, PROBE and DETECT.
REQ-018 IDLE: when any armed bit is set and all_finish=0, the FSM SHALL pick as origin the first armed index at or after the round-robin pointer rr (with wrap-around).
- On the same edge it SHALL load visited=frontier=onehot(origin) and move to PROBE.
REQ-019 PROBE SHALL compute next = (OR of wait_for rows i over frontier bits) & armed, advancing one hop per cycle.
REQ-020 In PROBE, if next[origin]=1, the FSM SHALL latch dl_members=visited and dl_origin=origin, then move to DETECT.
REQ-021 Otherwise, if (next & ~visited)==0, the FSM SHALL set rr=(origin+1) mod N_PROC and return to IDLE.
- Else it SHALL set frontier=next&~visited and visited|=next, and stay in PROBE.
REQ-022 A PROBE SHALL terminate within N_PROC cycles; visited grows strictly, so no hop counter overflow is possible.
REQ-023 If armed[origin] falls during PROBE, the FSM SHALL abort to IDLE with rr=(origin+1) mod N_PROC.
- If all_finish=1, it SHALL abort to IDLE with rr unchanged.
REQ-024 DETECT: dl_detect SHALL be 1 and dl_origin/dl_members held stable until dl_clear=1.
- dl_clear SHALL move the FSM to IDLE and zero dl_detect, dl_origin and dl_members on the next edge.
- stall_cnt SHALL be unaffected.
REQ-025 dl_clear SHALL be ignored outside DETECT.
REQ-026 all_finish=1 SHALL NOT clear an already-latched DETECT.
REQ-027 Self-wait (wait_for[i*N_PROC+i]=1 with armed[i]) SHALL be detected after exactly one PROBE cycle, with dl_members=onehot(i).
REQ-028 All outputs SHALL be registered; probe_busy=1 exactly when the state is PROBE.

Reset
REQ-029 dl_reset=0 SHALL asynchronously force IDLE, rr=0, every stall_cnt=0, visited=frontier=0, dl_detect=0, dl_origin=0, dl_members=0 and probe_busy=0.
REQ-030 Reset mid-PROBE or in DETECT SHALL discard all progress; after release, detection SHALL restart from counters at 0.

Verification (N_PROC=3, STALL_LIMIT=4)
REQ-031 Two-process cycle: P0->P1 and P1->P0, both blocked from cycle 0 -> counters reach 4 at edge 4, PROBE at edge 5, DETECT at edge 7; dl_detect=1, dl_origin=0, dl_members=3'b011.
REQ-032 Chain without cycle: P0->P1->P2, P2 not blocked -> probe from 0 fails, rr walks through 1; dl_detect stays 0 for 100 cycles; probe_busy pulses repeatedly.
REQ-033 Transient stall: P0/P1 mutual wait, but P1 blk deasserted for 1 cycle at cycle 3 -> counter 1 restarts; DETECT delayed by 4 cycles versus REQ-031.
REQ-034 Abort on unblock: three-cycle loop P0->P1->P2->P0, with P0 blk dropped on the first PROBE cycle -> return to IDLE, rr=1, no detect.
REQ-035 all_finish=1 asserted with the REQ-031 stimulus -> FSM never leaves IDLE; dl_detect=0.
REQ-036 Clear/re-detect: after REQ-031 DETECT, pulse dl_clear with the stimulus held -> dl_detect=0 for at least one cycle, then re-asserts (PROBE starts the next edge).
- Asserting dl_reset=0 mid-PROBE -> all outputs 0 immediately.

Source files
------------

// File: rtl/dataflow_deadlock_monitor.sv
// Dataflow deadlock monitor.
// Tracks how long each process has been blocked on another process. Once a
// process has stalled long enough it is "armed", and a probe walks the
// wait-for graph one hop per cycle, restricted to armed processes. When the
// probe returns to its origin, a deadlock cycle is latched until cleared.
module dataflow_deadlock_monitor #(
   parameter int N_PROC      = 3,
   parameter int STALL_LIMIT = 4,
   parameter int CNT_W       = 8,
   parameter int IDX_W       = $clog2(N_PROC)
) (
   input  logic                       dl_clock,
   input  logic                       dl_reset,
   input  logic [N_PROC-1:0]          proc_blk,
   input  logic [N_PROC*N_PROC-1:0]   wait_for,
   input  logic                       all_finish,
   input  logic                       dl_clear,
   output logic                       dl_detect,
   output logic [IDX_W-1:0]           dl_origin,
   output logic [N_PROC-1:0]          dl_members,
   output logic                       probe_busy
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_PROBE  = 2'd1;
   localparam logic [1:0] ST_DETECT = 2'd2;

   localparam logic [CNT_W-1:0]  LIMIT   = CNT_W'(STALL_LIMIT);
   localparam logic [N_PROC-1:0] ONE_HOT = N_PROC'(1);
   localparam logic [IDX_W-1:0]  LAST_ID = IDX_W'(N_PROC - 1);

   logic [CNT_W-1:0]  stall_cnt_q [N_PROC];
   logic [CNT_W-1:0]  stall_cnt_d [N_PROC];
   logic [N_PROC-1:0] armed;

   logic [1:0]        state_q, state_d;
   logic [IDX_W-1:0]  rr_q, rr_d;
   logic [IDX_W-1:0]  origin_q, origin_d;
   logic [N_PROC-1:0] visited_q, visited_d;
   logic [N_PROC-1:0] frontier_q, frontier_d;
   logic              dl_detect_q, dl_detect_d;
   logic [IDX_W-1:0]  dl_origin_q, dl_origin_d;
   logic [N_PROC-1:0] dl_members_q, dl_members_d;
   logic              probe_busy_q, probe_busy_d;

   logic              pick_found;
   logic [IDX_W-1:0]  pick_idx;
   logic [N_PROC-1:0] reach;
   logic [N_PROC-1:0] next_set;
   logic [N_PROC-1:0] fresh;
   logic [IDX_W-1:0]  rr_after;

   // Per-process saturating stall counters; armed once the limit is reached.
   always_comb begin
      for (int i = 0; i < N_PROC; i++) begin
         armed[i]       = (stall_cnt_q[i] == LIMIT);
         stall_cnt_d[i] = '0;
         if (proc_blk[i] && (wait_for[i*N_PROC +: N_PROC] != '0)) begin
            stall_cnt_d[i] = (stall_cnt_q[i] == LIMIT) ? LIMIT : stall_cnt_q[i] + CNT_W'(1);
         end
      end
   end

   // Round-robin choice of the next probe origin among armed processes.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int k = 0; k < N_PROC; k++) begin
         if (!pick_found && armed[(int'(rr_q) + k) % N_PROC]) begin
            pick_found = 1'b1;
            pick_idx   = IDX_W'((int'(rr_q) + k) % N_PROC);
         end
      end
   end

   // One probe hop: armed processes waited on by anything in the frontier.
   always_comb begin
      reach = '0;
      for (int i = 0; i < N_PROC; i++) begin
         if (frontier_q[i]) begin
            reach = reach | wait_for[i*N_PROC +: N_PROC];
         end
      end
      next_set = reach & armed;
      fresh    = next_set & ~visited_q;
      rr_after = (origin_q == LAST_ID) ? '0 : origin_q + IDX_W'(1);
   end

   // IDLE / PROBE / DETECT control and latching of the detection result.
   always_comb begin
      state_d      = state_q;
      rr_d         = rr_q;
      origin_d     = origin_q;
      visited_d    = visited_q;
      frontier_d   = frontier_q;
      dl_detect_d  = dl_detect_q;
      dl_origin_d  = dl_origin_q;
      dl_members_d = dl_members_q;
      case (state_q)
         ST_IDLE: begin
            if (!all_finish && pick_found) begin
               origin_d   = pick_idx;
               visited_d  = ONE_HOT << pick_idx;
               frontier_d = ONE_HOT << pick_idx;
               state_d    = ST_PROBE;
            end
         end
         ST_PROBE: begin
            if (all_finish) begin
               state_d = ST_IDLE;
            end else if (!armed[origin_q]) begin
               state_d = ST_IDLE;
               rr_d    = rr_after;
            end else if (next_set[origin_q]) begin
               state_d      = ST_DETECT;
               dl_detect_d  = 1'b1;
               dl_origin_d  = origin_q;
               dl_members_d = visited_q;
            end else if (fresh == '0) begin
               state_d = ST_IDLE;
               rr_d    = rr_after;
            end else begin
               frontier_d = fresh;
               visited_d  = visited_q | next_set;
            end
         end
         ST_DETECT: begin
            if (dl_clear) begin
               state_d      = ST_IDLE;
               dl_detect_d  = 1'b0;
               dl_origin_d  = '0;
               dl_members_d = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      probe_busy_d = (state_d == ST_PROBE);
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge dl_clock or negedge dl_reset) begin
      if (!dl_reset) begin
         for (int i = 0; i < N_PROC; i++) stall_cnt_q[i] <= '0;
         state_q      <= ST_IDLE;
         rr_q         <= '0;
         origin_q     <= '0;
         visited_q    <= '0;
         frontier_q   <= '0;
         dl_detect_q  <= 1'b0;
         dl_origin_q  <= '0;
         dl_members_q <= '0;
         probe_busy_q <= 1'b0;
      end else begin
         for (int i = 0; i < N_PROC; i++) stall_cnt_q[i] <= stall_cnt_d[i];
         state_q      <= state_d;
         rr_q         <= rr_d;
         origin_q     <= origin_d;
         visited_q    <= visited_d;
         frontier_q   <= frontier_d;
         dl_detect_q  <= dl_detect_d;
         dl_origin_q  <= dl_origin_d;
         dl_members_q <= dl_members_d;
         probe_busy_q <= probe_busy_d;
      end
   end

   assign dl_detect  = dl_detect_q;
   assign dl_origin  = dl_origin_q;
   assign dl_members = dl_members_q;
   assign probe_busy = probe_busy_q;

endmodule
